stripe_scheduler: RTL and testbench



---
 rtl/gene_pkg.sv | 21 ++
 rtl/stripe_b_loader.sv | 46 ++++
 rtl/stripe_scheduler.sv | 203 ++++++++++++++++++++
 tb/tb_stripe_scheduler.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gene_pkg.sv
// Shared constants, base/position types and the stripe scheduler state encoding.
package gene_pkg;

    localparam int unsigned N_PE    = 64;
    localparam int unsigned SEQ_LEN = 1024;
    localparam int unsigned SCORE_W = 14;

    typedef logic [1:0] base_t;
    typedef logic [9:0] pos_t;

    typedef enum logic [2:0] {
        StIdle,
        StLoadB,
        StGap,
        StStream,
        StDrain,
        StReport,
        StDone
    } state_e;

endpackage

// File: rtl/stripe_b_loader.sv
// Fetches the N_PE B bases of one stripe and holds them in the PE-facing slot register.
module stripe_b_loader #(
    parameter int unsigned N_PE = gene_pkg::N_PE
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                load_i,
    input  logic [3:0]          k_i,
    input  gene_pkg::base_t     b_data_i,
    output gene_pkg::pos_t      b_addr_o,
    output logic [2*N_PE-1:0]   pe_b_o,
    output logic                done_o
);
    import gene_pkg::*;

    localparam int unsigned CW = $clog2(N_PE + 1);

    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*N_PE-1:0] pe_b_q, pe_b_d;
    logic              issue;

    // cnt runs 0..N_PE: addresses go out on 0..N_PE-1, data lands on 1..N_PE.
    assign issue    = load_i && (cnt_q < CW'(N_PE));
    assign done_o   = load_i && (cnt_q == CW'(N_PE));
    assign b_addr_o = issue ? (pos_t'(k_i) * pos_t'(N_PE) + pos_t'(cnt_q)) : '0;
    assign pe_b_o   = pe_b_q;

    always_comb begin
        cnt_d  = load_i ? cnt_q + CW'(1) : '0;
        pe_b_d = pe_b_q;
        if (load_i && (cnt_q != '0)) begin
            pe_b_d[2*(int'(cnt_q) - 1) +: 2] = b_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            pe_b_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            pe_b_q <= pe_b_d;
        end
    end

endmodule

// File: rtl/stripe_scheduler.sv
// Stripe scheduler: loads a B window per stripe, streams A bases to the PE array,
// waits for the stripe end (or drain timeout) and reports one result per stripe.
module stripe_scheduler #(
    parameter int unsigned N_PE    = gene_pkg::N_PE,
    parameter int unsigned SEQ_LEN = gene_pkg::SEQ_LEN,
    parameter int unsigned SCORE_W = gene_pkg::SCORE_W,
    parameter int unsigned DRAIN   = 128
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_go,
    input  logic [4:0]          i_num_stripes,
    output logic                o_busy,
    output logic                o_done,
    output logic [9:0]          o_a_addr,
    input  logic [1:0]          i_a_data,
    output logic [9:0]          o_b_addr,
    input  logic [1:0]          i_b_data,
    output logic                o_pe_start,
    output logic [1:0]          o_pe_A,
    output logic [2*N_PE-1:0]   o_pe_B,
    input  logic                i_pe_stripe_end,
    input  logic [9:0]          i_pe_start_position,
    input  logic [9:0]          i_pe_end_position,
    input  logic [SCORE_W-1:0]  i_pe_max,
    output logic                o_res_valid,
    output logic [3:0]          o_res_stripe,
    output logic [9:0]          o_res_start,
    output logic [9:0]          o_res_end,
    output logic [SCORE_W-1:0]  o_res_max,
    output logic                o_res_overrun
);
    import gene_pkg::*;

    localparam pos_t        LastPos = pos_t'(SEQ_LEN - 1);
    localparam int unsigned DW      = $clog2(DRAIN + 1);

    // Reset asserts asynchronously but is released on a clock edge.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) rst_sync_q <= 2'b00;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    state_e              state_q, state_d;
    logic [3:0]          k_q, k_d;
    logic [4:0]          num_q, num_d;
    pos_t                s_q, s_d, a_addr_q, a_addr_d;
    logic                last_q, last_d;
    logic [DW-1:0]       drain_q, drain_d;
    pos_t                cap_end_q, cap_end_d, cap_sp_q, cap_sp_d;
    logic [SCORE_W-1:0]  cap_max_q, cap_max_d;
    logic                cap_ovr_q, cap_ovr_d;
    logic                take_pe, load_done;
    logic [10:0]         s_sum;
    logic [4:0]          k_inc;
    pos_t                b_addr;

    stripe_b_loader #(
        .N_PE (N_PE)
    ) u_b_loader (
        .clk_i    (i_clk),
        .rst_ni   (rst_n),
        .load_i   (state_q == StLoadB),
        .k_i      (k_q),
        .b_data_i (i_b_data),
        .b_addr_o (b_addr),
        .pe_b_o   (o_pe_B),
        .done_o   (load_done)
    );
    assign o_b_addr = b_addr;

    assign s_sum = {1'b0, s_q} + {1'b0, cap_sp_q};
    assign k_inc = {1'b0, k_q} + 5'd1;
    assign o_busy = (state_q != StIdle);

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        num_d       = num_q;
        s_d         = s_q;
        a_addr_d    = a_addr_q;
        last_d      = last_q;
        drain_d     = drain_q;
        cap_end_d   = cap_end_q;
        cap_sp_d    = cap_sp_q;
        cap_max_d   = cap_max_q;
        cap_ovr_d   = cap_ovr_q;
        take_pe     = 1'b0;
        o_a_addr    = '0;
        o_pe_start  = 1'b0;
        o_pe_A      = '0;
        o_res_valid = 1'b0;
        o_done      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (i_go) begin
                    state_d = StLoadB;
                    k_d     = '0;
                    s_d     = '0;
                    if (i_num_stripes == 5'd0)      num_d = 5'd1;
                    else if (i_num_stripes > 5'd16) num_d = 5'd16;
                    else                            num_d = i_num_stripes;
                end
            end
            StLoadB: begin
                if (load_done) state_d = StGap;
            end
            StGap: begin
                // First A read goes out here so data is valid on the first STREAM cycle.
                o_a_addr = s_q;
                a_addr_d = s_q + pos_t'(1);
                last_d   = (s_q == LastPos);
                state_d  = StStream;
            end
            StStream: begin
                o_pe_start = 1'b1;
                o_pe_A     = i_a_data;
                if (!last_q) begin
                    o_a_addr = a_addr_q;
                    a_addr_d = a_addr_q + pos_t'(1);
                    last_d   = (a_addr_q == LastPos);
                end
                if (i_pe_stripe_end) begin
                    take_pe = 1'b1;
                    state_d = StReport;
                end else if (last_q) begin
                    drain_d = '0;
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (i_pe_stripe_end) begin
                    take_pe = 1'b1;
                    state_d = StReport;
                end else if (drain_q == DW'(DRAIN - 1)) begin
                    cap_end_d = LastPos;
                    cap_max_d = '0;
                    cap_sp_d  = '0;
                    cap_ovr_d = 1'b1;
                    state_d   = StReport;
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            StReport: begin
                o_res_valid = 1'b1;
                s_d         = (s_sum > {1'b0, LastPos}) ? LastPos : s_sum[9:0];
                k_d         = k_inc[3:0];
                state_d     = (k_inc == num_q) ? StDone : StLoadB;
            end
            StDone: begin
                o_done  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (take_pe) begin
            cap_end_d = i_pe_end_position;
            cap_max_d = i_pe_max;
            cap_sp_d  = i_pe_start_position;
            cap_ovr_d = 1'b0;
        end
    end

    assign o_res_stripe  = o_res_valid ? k_q       : '0;
    assign o_res_start   = o_res_valid ? s_q       : '0;
    assign o_res_end     = o_res_valid ? cap_end_q : '0;
    assign o_res_max     = o_res_valid ? cap_max_q : '0;
    assign o_res_overrun = o_res_valid & cap_ovr_q;

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            k_q       <= '0;
            num_q     <= '0;
            s_q       <= '0;
            a_addr_q  <= '0;
            last_q    <= 1'b0;
            drain_q   <= '0;
            cap_end_q <= '0;
            cap_sp_q  <= '0;
            cap_max_q <= '0;
            cap_ovr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            num_q     <= num_d;
            s_q       <= s_d;
            a_addr_q  <= a_addr_d;
            last_q    <= last_d;
            drain_q   <= drain_d;
            cap_end_q <= cap_end_d;
            cap_sp_q  <= cap_sp_d;
            cap_max_q <= cap_max_d;
            cap_ovr_q <= cap_ovr_d;
        end
    end

endmodule

// File: tb/tb_stripe_scheduler.sv
// Randomized bench for stripe_scheduler with behavioural memories, PE model and result model.
module tb_stripe_scheduler;
    localparam int NPE = 64;
    localparam int SEQ = 1024;
    localparam int SW  = 14;
    localparam int DRN = 128;

    logic clk = 1'b0, rst_n = 1'b0, go = 1'b0;
    logic [4:0] num_stripes = '0;
    logic busy, done, pe_start, stripe_end, res_valid, res_ovr;
    logic [9:0] a_addr, b_addr, sp_in, ep_in, res_start, res_end;
    logic [1:0] a_data, b_data, pe_a;
    logic [127:0] pe_b;
    logic [3:0] res_stripe;
    logic [SW-1:0] max_in, res_max;
    logic [192:0] all_outs;

    logic [1:0] a_mem [SEQ];
    logic [1:0] b_mem [SEQ];
    int after_tbl [16];
    int sp_tbl [16];
    int ep_tbl [16];
    int max_tbl [16];
    int pe_k, pe_cnt;
    int n_checks = 0, n_pass = 0;

    always #5 clk = ~clk;

    stripe_scheduler dut (
        .i_clk (clk), .i_rst_n (rst_n), .i_go (go), .i_num_stripes (num_stripes),
        .o_busy (busy), .o_done (done), .o_a_addr (a_addr), .i_a_data (a_data),
        .o_b_addr (b_addr), .i_b_data (b_data), .o_pe_start (pe_start), .o_pe_A (pe_a),
        .o_pe_B (pe_b), .i_pe_stripe_end (stripe_end), .i_pe_start_position (sp_in),
        .i_pe_end_position (ep_in), .i_pe_max (max_in), .o_res_valid (res_valid),
        .o_res_stripe (res_stripe), .o_res_start (res_start), .o_res_end (res_end),
        .o_res_max (res_max), .o_res_overrun (res_ovr)
    );

    assign all_outs = {busy, done, pe_start, res_valid, res_ovr, a_addr, b_addr, pe_a, pe_b,
                       res_stripe, res_start, res_end, res_max};

    // Sequence memories: one-cycle read latency.
    always @(posedge clk) begin
        a_data <= a_mem[a_addr];
        b_data <= b_mem[b_addr];
    end

    // PE array model: ends stripe k after after_tbl[k] streamed bases (0 = never).
    always @(posedge clk) begin
        if (!rst_n || done) begin
            pe_k <= 0; pe_cnt <= 0;
        end else if (res_valid) begin
            pe_k <= pe_k + 1; pe_cnt <= 0;
        end else if (pe_start) begin
            pe_cnt <= pe_cnt + 1;
        end
    end
    assign stripe_end = pe_start && (after_tbl[pe_k & 15] != 0) &&
                        (pe_cnt + 1 == after_tbl[pe_k & 15]);
    assign sp_in  = 10'(sp_tbl[pe_k & 15]);
    assign ep_in  = 10'(ep_tbl[pe_k & 15]);
    assign max_in = SW'(max_tbl[pe_k & 15]);

    task automatic fill_random();
        for (int k = 0; k < 16; k++) begin
            after_tbl[k] = ($urandom_range(7) == 0) ? 0 : int'($urandom_range(300, 1));
            sp_tbl[k]    = int'($urandom_range(400));
            ep_tbl[k]    = int'($urandom_range(SEQ - 1));
            max_tbl[k]   = int'($urandom_range((1 << SW) - 1));
        end
    endtask

    task automatic run_case(input string name, input int n_in, input int n_exp,
                            input int extra_go_cyc, input int abort_k);
        int exp_start [16];
        int exp_end [16];
        int exp_max [16];
        int exp_cnt [16];
        bit exp_ovr [16];
        int s, avail, rk, cyc, st_cnt, last_b, last_st, last_res, a_err, limit, hits;
        bit prev_start, finished;
        logic [127:0] win;
        s = 0;
        for (int k = 0; k < n_exp; k++) begin
            exp_start[k] = s;
            avail = SEQ - s;
            if (after_tbl[k] != 0 && after_tbl[k] <= avail) begin
                exp_ovr[k] = 1'b0; exp_end[k] = ep_tbl[k]; exp_max[k] = max_tbl[k];
                exp_cnt[k] = after_tbl[k];
                s = s + sp_tbl[k];
                if (s > SEQ - 1) s = SEQ - 1;
            end else begin
                exp_ovr[k] = 1'b1; exp_end[k] = SEQ - 1; exp_max[k] = 0; exp_cnt[k] = avail;
            end
        end
        rk = 0; cyc = 0; st_cnt = 0; last_b = -100; last_st = 0; last_res = 0; a_err = 0;
        prev_start = 1'b0; finished = 1'b0; hits = 0;
        limit = 1300 * n_exp + 300;
        num_stripes = 5'(n_in);
        go = 1'b1;
        while (!finished && cyc < limit) begin
            @(negedge clk);
            cyc++;
            go = (cyc == extra_go_cyc);
            if (b_addr == 10'(rk * NPE + NPE - 1)) last_b = cyc;
            if (pe_start) begin
                if (!prev_start) begin
                    for (int i = 0; i < NPE; i++) win[2*i +: 2] = b_mem[(rk * NPE + i) % SEQ];
                    n_checks++;
                    if (cyc - last_b != 3)
                        $display("FAIL %s gap stripe %0d: stream began %0d cycles after last B address, want 3",
                                 name, rk, cyc - last_b);
                    else n_pass++;
                    n_checks++;
                    if (pe_b !== win)
                        $display("FAIL %s b_window stripe %0d: got %h want %h", name, rk, pe_b, win);
                    else n_pass++;
                    st_cnt = 0; a_err = 0;
                end
                if (pe_a !== a_mem[(exp_start[rk & 15] + st_cnt) % SEQ]) a_err++;
                st_cnt++;
                last_st = cyc;
                if (abort_k == rk && st_cnt == 5) begin
                    #2 rst_n = 1'b0;
                    #1;
                    n_checks++;
                    if (all_outs !== '0)
                        $display("FAIL %s reset_outputs: got %h want 0", name, all_outs);
                    else n_pass++;
                    repeat (3) begin
                        @(negedge clk);
                        if (res_valid || done || busy) hits++;
                    end
                    rst_n = 1'b1;
                    repeat (20) begin
                        @(negedge clk);
                        if (res_valid || done || busy) hits++;
                    end
                    n_checks++;
                    if (hits != 0)
                        $display("FAIL %s post_reset_activity: %0d active cycles, want 0", name, hits);
                    else n_pass++;
                    go = 1'b0;
                    return;
                end
            end
            if (res_valid) begin
                n_checks++;
                if (rk >= n_exp)
                    $display("FAIL %s extra_result: result %0d, want only %0d", name, rk, n_exp);
                else if ({res_stripe, res_start, res_end, res_max, res_ovr} !==
                         {4'(rk), 10'(exp_start[rk]), 10'(exp_end[rk]), SW'(exp_max[rk]), exp_ovr[rk]})
                    $display("FAIL %s result %0d: got k=%0d start=%0d end=%0d max=%0d ovr=%0b want k=%0d start=%0d end=%0d max=%0d ovr=%0b",
                             name, rk, res_stripe, res_start, res_end, res_max, res_ovr,
                             rk, exp_start[rk], exp_end[rk], exp_max[rk], exp_ovr[rk]);
                else n_pass++;
                if (rk < n_exp) begin
                    n_checks++;
                    if (st_cnt != exp_cnt[rk] || a_err != 0)
                        $display("FAIL %s stream %0d: got %0d bases (%0d wrong) want %0d bases (0 wrong)",
                                 name, rk, st_cnt, a_err, exp_cnt[rk]);
                    else n_pass++;
                    if (exp_ovr[rk]) begin
                        n_checks++;
                        if (cyc - last_st != DRN + 1)
                            $display("FAIL %s drain %0d: report %0d cycles after last A base, want %0d",
                                     name, rk, cyc - last_st, DRN + 1);
                        else n_pass++;
                    end
                end
                rk++;
                last_res = cyc;
                st_cnt = 0; a_err = 0;
            end
            if (done) begin
                n_checks++;
                if (rk != n_exp || cyc - last_res != 1 || busy !== 1'b1)
                    $display("FAIL %s done: got results=%0d delay=%0d busy=%0b want results=%0d delay=1 busy=1",
                             name, rk, cyc - last_res, busy, n_exp);
                else n_pass++;
                finished = 1'b1;
            end
            prev_start = pe_start;
        end
        go = 1'b0;
        n_checks++;
        if (!finished) begin
            $display("FAIL %s timeout: got no o_done in %0d cycles, want o_done", name, limit);
        end else begin
            @(negedge clk);
            if (busy !== 1'b0) $display("FAIL %s idle: got busy=%0b want 0", name, busy);
            else n_pass++;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (all_outs !== '0) $display("FAIL reset_state: got %h want 0", all_outs);
        else n_pass++;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) $display("FAIL reset_release: got busy=%0b want 0", busy);
        else n_pass++;
    endtask

    task automatic test_single();
        fill_random();
        after_tbl[0] = 300; sp_tbl[0] = 40; max_tbl[0] = 200;
        run_case("single", 1, 1, -1, -1);
    endtask

    task automatic test_five();
        fill_random();
        for (int k = 0; k < 5; k++) begin
            after_tbl[k] = int'($urandom_range(120, 20)); sp_tbl[k] = 100;
        end
        run_case("five", 5, 5, -1, -1);
    endtask

    task automatic test_overrun();
        fill_random();
        after_tbl[0] = 0;
        run_case("overrun", 1, 1, -1, -1);
    endtask

    task automatic test_saturate();
        fill_random();
        after_tbl[0] = 50; sp_tbl[0] = 1000;
        after_tbl[1] = 10; sp_tbl[1] = 100;
        after_tbl[2] = 1;
        run_case("saturate", 3, 3, -1, -1);
    endtask

    task automatic test_go_busy();
        fill_random();
        after_tbl[0] = 40;
        run_case("go_busy", 0, 1, 10, -1);
    endtask

    task automatic test_first_end();
        fill_random();
        after_tbl[0] = 1; sp_tbl[0] = 5;
        after_tbl[1] = 1;
        run_case("first_end", 2, 2, -1, -1);
    endtask

    task automatic test_reset_midrun();
        fill_random();
        for (int k = 0; k < 4; k++) begin
            after_tbl[k] = 50; sp_tbl[k] = 10;
        end
        run_case("reset_midrun", 4, 4, -1, 2);
        repeat (4) @(negedge clk);
    endtask

    task automatic test_random();
        int n;
        for (int r = 0; r < 3; r++) begin
            fill_random();
            n = int'($urandom_range(5, 1));
            run_case("random", n, n, -1, -1);
        end
    endtask

    initial begin
        for (int i = 0; i < SEQ; i++) begin
            a_mem[i] = 2'($urandom);
            b_mem[i] = 2'($urandom);
        end
        fill_random();
        test_reset();
        test_single();
        test_five();
        test_overrun();
        test_saturate();
        test_go_busy();
        test_first_end();
        test_reset_midrun();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
